rx_frame_parser: RTL

- Sits directly downstream of the FPGA slave receiver and consumes its out_enable/out_data byte stream.
- Finds frames of the form SYNC, LEN, LEN payload bytes, CHK. Checks them and holds one good frame in an internal buffer.
- Hands the buffered frame to fabric logic through a first-word-fall-through read port.
- Reports checksum, length, timeout and overrun faults.

---
 rtl/rx_frame_parser_if.sv | 24 ++
 rtl/rx_frame_parser.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_parser_if.sv
// Byte-stream input, show-ahead read port and status pulses of rx_frame_parser.
// The parser takes the slave modport; the upstream receiver/fabric side takes master.
interface rx_frame_parser_if;
  logic       in_enable;
  logic [7:0] in_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic [7:0] frame_len;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       overrun;

  modport master (
    output in_enable, in_data, rd_en,
    input  rd_data, rd_empty, frame_len, frame_done, frame_err, err_code, overrun
  );

  modport slave (
    input  in_enable, in_data, rd_en,
    output rd_data, rd_empty, frame_len, frame_done, frame_err, err_code, overrun
  );
endinterface

// File: rtl/rx_frame_parser.sv
// Frame parser: SYNC, LEN, payload, CHK (LEN ^ payload); buffers one good frame for FWFT reads.
// Optional mid-frame idle timeout is enabled with `define RX_PARSER_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | hunting for SYNC_BYTE (also the only state while the buffer is occupied)
//   LEN     | next byte is the payload length
//   PAYLOAD | storing payload bytes into the buffer
//   CHK     | next byte is the checksum; commit or discard
module rx_frame_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  rx_frame_parser_if.slave   bus
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         DEPTH     = 1 << AW;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
    $error("rx_frame_parser: MAX_LEN must be 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("rx_frame_parser: TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHK     = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic       rd_empty_q, rd_empty_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       overrun_q, overrun_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

`ifdef RX_PARSER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
  logic [15:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_len_d = frame_len_q;
    rd_empty_d  = rd_empty_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    overrun_d   = 1'b0;
    mem_d       = mem_q;
`ifdef RX_PARSER_TIMEOUT_EN
    timer_d     = timer_q;
`endif

    if (bus.rd_en && !rd_empty_q) begin
      if (rd_ptr_q == frame_len_q - 8'd1) begin
        rd_empty_d  = 1'b1;
        rd_ptr_d    = 8'd0;
        frame_len_d = 8'd0;
      end else begin
        rd_ptr_d = rd_ptr_q + 8'd1;
      end
    end

    if (bus.in_enable) begin
      // Buffer still holds a frame (even if it is being drained this cycle): drop.
      if (!rd_empty_q) begin
        overrun_d = 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.in_data == SYNC_BYTE) state_d = S_LEN;
          end
          S_LEN: begin
            len_d    = bus.in_data;
            acc_d    = bus.in_data;
            wr_ptr_d = 8'd0;
            if (bus.in_data > MAX_LEN_B) begin
              err_d      = 1'b1;
              err_code_d = 2'd2;
              state_d    = S_IDLE;
            end else if (bus.in_data == 8'd0) begin
              state_d = S_CHK;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            mem_d[wr_ptr_q[AW-1:0]] = bus.in_data;
            acc_d    = acc_q ^ bus.in_data;
            wr_ptr_d = wr_ptr_q + 8'd1;
            if (wr_ptr_q + 8'd1 == len_q) state_d = S_CHK;
          end
          S_CHK: begin
            if (bus.in_data == acc_q) begin
              done_d      = 1'b1;
              frame_len_d = len_q;
              rd_empty_d  = (len_q == 8'd0);
              rd_ptr_d    = 8'd0;
            end else begin
              err_d      = 1'b1;
              err_code_d = 2'd1;
            end
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

`ifdef RX_PARSER_TIMEOUT_EN
    // A byte in the expiry cycle wins: it is processed above and the timer restarts.
    if (bus.in_enable || state_q == S_IDLE) begin
      timer_d = 16'd0;
    end else if (timer_q == TIMEOUT_M1) begin
      timer_d    = 16'd0;
      err_d      = 1'b1;
      err_code_d = 2'd3;
      state_d    = S_IDLE;
    end else begin
      timer_d = timer_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      acc_q       <= 8'd0;
      wr_ptr_q    <= 8'd0;
      rd_ptr_q    <= 8'd0;
      frame_len_q <= 8'd0;
      rd_empty_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      overrun_q   <= 1'b0;
`ifdef RX_PARSER_TIMEOUT_EN
      timer_q     <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_len_q <= frame_len_d;
      rd_empty_q  <= rd_empty_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
`ifdef RX_PARSER_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  // Payload storage carries no reset; rd_empty gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.rd_data    = rd_empty_q ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.rd_empty   = rd_empty_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.overrun    = overrun_q;

endmodule
